// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART: state encoding, parity modes
// and baud divider helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int calc_baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Width of a counter running 0..div-1; never narrower than one bit.
  function automatic int calc_cnt_width(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: tick pulses on the last cycle of every BAUD_DIV enabled
// cycles. clear restarts the period from zero.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int W = calc_cnt_width(BAUD_DIV);
  localparam logic [W-1:0] LAST = W'(BAUD_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Combinational so the consumer can act on the boundary edge itself.
  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, 5..8 data bits LSB first,
// optional parity, 1 or 2 stop bits, valid/ready input handshake.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic [DATA_BITS-1:0] data,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic                 dout
);

  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  if (BAUD_DIV < 2) begin : g_bad_baud
    $error("uart_tx_param: CLK_FREQ/BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be 5..8");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  // Handshake: a word transfers on a rising edge where valid && ready are
  // both high; ready is registered, so valid never reaches an output
  // combinationally.
  state_t               state, state_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_bit, par_bit_n;
  logic [2:0]           bit_cnt, bit_cnt_n;
  logic                 dout_n, ready_n, busy_n, done_n;
  logic                 accept;
  logic                 tick;

  assign accept = valid && ready;

  uart_baud_tick #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .enable(state != ST_IDLE),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      par_bit <= 1'b0;
      bit_cnt <= '0;
      dout    <= 1'b1;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      par_bit <= par_bit_n;
      bit_cnt <= bit_cnt_n;
      dout    <= dout_n;
      ready   <= ready_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    par_bit_n = par_bit;
    bit_cnt_n = bit_cnt;
    dout_n    = dout;
    ready_n   = ready;
    busy_n    = busy;
    done_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_n   = ST_START;
          shreg_n   = data;
          par_bit_n = (PARITY == PAR_EVEN) ? ^data : ~^data;
          bit_cnt_n = '0;
          dout_n    = 1'b0;
          ready_n   = 1'b0;
          busy_n    = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          state_n   = ST_DATA;
          dout_n    = shreg[0];
          shreg_n   = shreg >> 1;
          bit_cnt_n = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_n = '0;
            if (PARITY != PAR_NONE) begin
              state_n = ST_PARITY;
              dout_n  = par_bit;
            end else begin
              state_n = ST_STOP;
              dout_n  = 1'b1;
            end
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
            dout_n    = shreg[0];
            shreg_n   = shreg >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_n   = ST_STOP;
          dout_n    = 1'b1;
          bit_cnt_n = '0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_cnt == LAST_STOP) begin
            state_n = ST_IDLE;
            ready_n = 1'b1;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            dout_n  = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four configurations (8N1, 8E1, 8O1, 7N2) at
// BAUD_DIV=10, checked cycle by cycle against an expected-waveform queue.
module tb_uart_tx_param;
  import uart_pkg::*;

  localparam int BD   = 10;
  localparam int NONE = -10;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid [4];
  logic [7:0] data  [4];
  logic       dout  [4];
  logic       ready [4];
  logic       busy  [4];
  logic       done  [4];

  int checks = 0;
  int errors = 0;

  // Each entry is the expected {dout, ready, busy, done} for one cycle.
  logic [3:0] exp_q[$];

  typedef struct {
    int          idx;
    logic [7:0]  d;
    logic [11:0] bits;
    int          n;
  } vec_t;
  vec_t tbl[4];

  always #5 clk = ~clk;

  uart_tx_param #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1))
  u_8n1 (.clk(clk), .rst(rst), .valid(valid[0]), .data(data[0]),
         .ready(ready[0]), .busy(busy[0]), .done(done[0]), .dout(dout[0]));

  uart_tx_param #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1))
  u_8e1 (.clk(clk), .rst(rst), .valid(valid[1]), .data(data[1]),
         .ready(ready[1]), .busy(busy[1]), .done(done[1]), .dout(dout[1]));

  uart_tx_param #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(1))
  u_8o1 (.clk(clk), .rst(rst), .valid(valid[2]), .data(data[2]),
         .ready(ready[2]), .busy(busy[2]), .done(done[2]), .dout(dout[2]));

  uart_tx_param #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(7), .PARITY(PAR_NONE), .STOP_BITS(2))
  u_7n2 (.clk(clk), .rst(rst), .valid(valid[3]), .data(data[3][6:0]),
         .ready(ready[3]), .busy(busy[3]), .done(done[3]), .dout(dout[3]));

  // Reference frame builder: bit i of 'bits' is the i-th bit on the line.
  function automatic void make_frame(input int idx, input logic [7:0] d,
                                     output logic [11:0] bits, output int n);
    int nd, par, st, ones;
    case (idx)
      0:       begin nd = 8; par = PAR_NONE; st = 1; end
      1:       begin nd = 8; par = PAR_EVEN; st = 1; end
      2:       begin nd = 8; par = PAR_ODD;  st = 1; end
      default: begin nd = 7; par = PAR_NONE; st = 2; end
    endcase
    bits = '0;
    n    = 1;
    ones = 0;
    for (int i = 0; i < nd; i++) begin
      bits[n] = d[i];
      if (d[i]) ones++;
      n++;
    end
    if (par != PAR_NONE) begin
      bits[n] = (par == PAR_EVEN) ? ((ones % 2) == 1) : ((ones % 2) == 0);
      n++;
    end
    for (int s = 0; s < st; s++) begin
      bits[n] = 1'b1;
      n++;
    end
  endfunction

  // Push the line waveform of a frame; upto < 0 means the whole frame plus
  // the end-of-frame cycle (ready back, done pulse).
  task automatic push_frame(input logic [11:0] bits, input int n, input int upto);
    for (int c = 0; c < n * BD; c++) begin
      if (upto < 0 || c < upto) exp_q.push_back({bits[c / BD], 1'b0, 1'b1, 1'b0});
    end
    if (upto < 0) exp_q.push_back(4'b1101);
  endtask

  task automatic push_idle(input int cycles);
    for (int c = 0; c < cycles; c++) exp_q.push_back(4'b1100);
  endtask

  task automatic check(input string name, input int k, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s k=%0d {dout,ready,busy,done} got=%b expected=%b", name, k, got, exp);
    end
  endtask

  // Offer d, then compare one queue entry per cycle starting right after the
  // accept edge. Optional per-cycle events: drop valid, a one-cycle valid
  // pulse, a one-cycle reset; data is changed to d_after once accepted.
  task automatic run_stream(input string name, input int idx, input logic [7:0] d,
                            input logic [7:0] d_after, input int drop_k,
                            input int pulse_k, input logic [7:0] pulse_d, input int rst_k);
    int k;
    logic [3:0] exp;
    @(negedge clk);
    valid[idx] = 1'b1;
    data[idx]  = d;
    @(posedge clk);
    #1;
    k = 0;
    while (exp_q.size() > 0) begin
      if (k == 0) data[idx] = d_after;
      if (k == drop_k) valid[idx] = 1'b0;
      if (k == pulse_k) begin
        valid[idx] = 1'b1;
        data[idx]  = pulse_d;
      end
      if (k == pulse_k + 1) valid[idx] = 1'b0;
      if (k == rst_k) rst = 1'b1;
      if (k == rst_k + 1) rst = 1'b0;
      exp = exp_q.pop_front();
      check(name, k, {dout[idx], ready[idx], busy[idx], done[idx]}, exp);
      @(posedge clk);
      #1;
      k++;
    end
    valid[idx] = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] b1, b2;
    int n1, n2, idx;
    logic [7:0] d;

    // Spec vectors; expected line bits written out by hand, LSB = first bit.
    tbl[0] = '{idx: 0, d: 8'h55, bits: 12'h2AA, n: 10};
    tbl[1] = '{idx: 1, d: 8'h07, bits: 12'h60E, n: 11};
    tbl[2] = '{idx: 2, d: 8'h07, bits: 12'h40E, n: 11};
    tbl[3] = '{idx: 3, d: 8'h41, bits: 12'h382, n: 10};

    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid[i] = 1'b0;
      data[i]  = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset[%0d]", i), 0, {dout[i], ready[i], busy[i], done[i]}, 4'b1100);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("post_reset[%0d]", i), 0, {dout[i], ready[i], busy[i], done[i]}, 4'b1100);
    end

    for (int i = 0; i < 4; i++) begin
      push_frame(tbl[i].bits, tbl[i].n, -1);
      push_idle(1);
      run_stream($sformatf("table[%0d]", i), tbl[i].idx, tbl[i].d, ~tbl[i].d, 0, NONE, 8'h00, NONE);
    end

    // Back-to-back: valid stays high; the second word is taken on the first
    // edge where ready is back, one cycle after the first done pulse.
    make_frame(0, 8'hA5, b1, n1);
    make_frame(0, 8'h3C, b2, n2);
    push_frame(b1, n1, -1);
    push_frame(b2, n2, -1);
    push_idle(2);
    run_stream("back_to_back", 0, 8'hA5, 8'h3C, 101, NONE, 8'h00, NONE);

    // valid pulse with 0xFF mid-frame is ignored.
    make_frame(0, 8'h00, b1, n1);
    push_frame(b1, n1, -1);
    push_idle(1);
    run_stream("ignore_busy", 0, 8'h00, 8'h00, 0, 35, 8'hFF, NONE);

    // Reset during data bit 3 (cycles 40..49): line idle on the next edge, no done.
    make_frame(0, 8'h3C, b1, n1);
    push_frame(b1, n1, 45);
    push_idle(70);
    run_stream("reset_mid_frame", 0, 8'h3C, 8'hC3, 0, NONE, 8'h00, 44);

    make_frame(0, 8'h81, b1, n1);
    push_frame(b1, n1, -1);
    push_idle(1);
    run_stream("after_reset", 0, 8'h81, 8'h7E, 0, NONE, 8'h00, NONE);

    for (int r = 0; r < 8; r++) begin
      idx = r % 4;
      d   = 8'($urandom_range(0, 255));
      if (idx == 3) d[7] = 1'b0;
      make_frame(idx, d, b1, n1);
      push_frame(b1, n1, -1);
      push_idle(1);
      run_stream($sformatf("random[%0d] d=%h", r, d), idx, d, ~d, 0, NONE, 8'h00, NONE);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
